// File: rtl/wb_copy_pkg.sv
`default_nettype none
// ============================================================================
// wb_copy_pkg : shared widths, FSM state type and watchdog default
// Rev 1.0
// ============================================================================
package wb_copy_pkg;

  localparam int ADDR_WIDTH_DEFAULT     = 11;
  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int SEL_WIDTH_DEFAULT      = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FIN     = 3'd5
  } wb_copy_state_t;

  // True while the engine owns the bus (cyc asserted).
  function automatic logic is_bus_state(input wb_copy_state_t s);
    return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ) || (s == WR_WAIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_copy_watchdog.sv
`default_nettype none
// ============================================================================
// wb_copy_watchdog : counts cycles spent in one bus state, flags expiry
// Rev 1.0
// ============================================================================
module wb_copy_watchdog
  import wb_copy_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_restart,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_active || i_restart) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // r_cnt is the number of cycles already spent in the current state,
  // so the last permitted cycle is TIMEOUT_CYCLES-1.
  assign o_expire = i_active && !i_restart && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/wb_copy_engine.sv
`default_nettype none
// ============================================================================
// wb_copy_engine : word-by-word Wishbone memory copy (read then write)
// Optional watchdog enabled by defining WB_COPY_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module wb_copy_engine
  import wb_copy_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int SEL_WIDTH      = SEL_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [ADDR_WIDTH-2:0] len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-2:0] words_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i
);

  localparam int WA = ADDR_WIDTH - 2;
  localparam int LW = ADDR_WIDTH - 1;

  wb_copy_state_t r_state;
  wb_copy_state_t w_next_base;
  wb_copy_state_t w_next;

  logic [WA-1:0]         r_src;
  logic [WA-1:0]         r_dst;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_words;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_last;
  logic                  w_expire;
  logic                  w_start;

  // Word addresses only: the byte-lane bits are forced to zero on the bus.
  logic w_unused;
  assign w_unused = ^{src_addr_i[1:0], dst_addr_i[1:0]};

  assign w_start = (r_state == IDLE) && start_i;
  assign w_last  = (r_words + LW'(1)) == r_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next_base = r_state;
    busy_o      = (r_state != IDLE);
    done_o      = (r_state == FIN);
    wb_cyc_o    = is_bus_state(r_state);
    wb_stb_o    = (r_state == RD_REQ) || (r_state == WR_REQ);
    wb_we_o     = (r_state == WR_REQ) || (r_state == WR_WAIT);
    wb_sel_o    = wb_cyc_o ? {SEL_WIDTH{1'b1}} : {SEL_WIDTH{1'b0}};
    wb_addr_o   = wb_we_o ? {r_dst, 2'b00} : {r_src, 2'b00};
    case (r_state)
      IDLE:    if (start_i)     w_next_base = (len_i == '0) ? FIN : RD_REQ;
      RD_REQ:  if (!wb_stall_i) w_next_base = RD_WAIT;
      RD_WAIT: if (wb_ack_i)    w_next_base = WR_REQ;
      WR_REQ:  if (!wb_stall_i) w_next_base = WR_WAIT;
      WR_WAIT: if (wb_ack_i)    w_next_base = w_last ? FIN : RD_REQ;
      FIN:                      w_next_base = IDLE;
      default:                  w_next_base = IDLE;
    endcase
  end

  // Timeout overrides only a state that would otherwise stay put.
  assign w_next = w_expire ? FIN : w_next_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_src   <= src_addr_i[ADDR_WIDTH-1:2];
          r_dst   <= dst_addr_i[ADDR_WIDTH-1:2];
          r_len   <= len_i;
          r_words <= '0;
        end
        RD_WAIT: if (wb_ack_i) r_data <= wb_data_i;
        WR_WAIT: if (wb_ack_i) begin
          r_words <= r_words + LW'(1);
          r_src   <= r_src + WA'(1);
          r_dst   <= r_dst + WA'(1);
        end
        default: ;
      endcase
    end
  end

  assign words_o   = r_words;
  assign wb_data_o = r_data;

`ifdef WB_COPY_TIMEOUT_EN
  logic w_active;
  logic w_restart;
  logic r_err;

  assign w_active  = is_bus_state(r_state);
  assign w_restart = (w_next_base != r_state);

  wb_copy_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_restart (w_restart),
    .o_expire  (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0) ^ w_start;
  assign w_expire     = 1'b0;
  assign err_o        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_copy_engine.sv
`default_nettype none
// tb_wb_copy_engine : directed copy scenarios against a one-port Wishbone RAM
// model with programmable stall and ack suppression.
module tb_wb_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [10:0] src_addr_i = '0;
  logic [10:0] dst_addr_i = '0;
  logic [9:0]  len_i = '0;
  logic        busy_o, done_o, err_o;
  logic [9:0]  words_o;
  logic [10:0] wb_addr_o;
  logic [31:0] wb_data_o, wb_data_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_stall_i;

  always #5 clk = ~clk;

  wb_copy_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .words_o    (words_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i)
  );

  // ---------------- RAM model ----------------
  logic [31:0] mem [512];
  int          stall_n = 0;
  int          stall_cnt = 0;
  logic        no_ack = 1'b0;
  logic        poke_en = 1'b0;
  logic [8:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic        r_ack = 1'b0;
  logic [31:0] r_rdata = '0;

  assign wb_stall_i = wb_cyc_o && wb_stb_o && (stall_cnt < stall_n);
  assign wb_ack_i   = r_ack;
  assign wb_data_i  = r_rdata;

  always @(posedge clk) begin
    r_ack <= 1'b0;
    if (poke_en) mem[poke_idx] <= poke_val;
    if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
      if (wb_we_o) mem[wb_addr_o[10:2]] <= wb_data_o;
      else         r_rdata <= mem[wb_addr_o[10:2]];
      r_ack     <= !no_ack;
      stall_cnt <= 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      stall_cnt <= stall_cnt + 1;
    end else begin
      stall_cnt <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  int          done_cnt = 0, cyc_cnt = 0, stall_cyc = 0, stab_err = 0, rd_n = 0;
  logic [10:0] rd_log [64];
  logic        prev_hold = 1'b0;
  logic [10:0] prev_addr = '0;

  always @(negedge clk) begin
    if (done_o)   done_cnt <= done_cnt + 1;
    if (wb_cyc_o) cyc_cnt  <= cyc_cnt + 1;
    if (wb_stb_o && wb_stall_i) stall_cyc <= stall_cyc + 1;
    if (prev_hold && (!wb_stb_o || wb_addr_o !== prev_addr)) stab_err <= stab_err + 1;
    prev_hold <= wb_stb_o && wb_stall_i;
    prev_addr <= wb_addr_o;
    if (wb_stb_o && !wb_stall_i && !wb_we_o && rd_n < 64) begin
      rd_log[rd_n[5:0]] <= wb_addr_o;
      rd_n <= rd_n + 1;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    @(posedge clk); #1;
    poke_en  = 1'b1;
    poke_idx = idx[8:0];
    poke_val = v;
    @(posedge clk); #1;
    poke_en  = 1'b0;
  endtask

  task automatic start_copy(input logic [10:0] s, input logic [10:0] d, input logic [9:0] l);
    @(posedge clk); #1;
    src_addr_i = s;
    dst_addr_i = d;
    len_i      = l;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
  endtask

  // lat = number of negedges waited before done_o was seen (0 = first one).
  task automatic wait_done(input int budget, output int lat, output logic seen);
    lat  = -1;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int   lat, d0, c0, s0, sc0, r0;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ctrl",  {26'd0, busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk_eq("rst_words", {22'd0, words_o}, 32'd0);
    chk_eq("rst_addr",  {21'd0, wb_addr_o}, 32'd0);
    chk_eq("rst_data",  wb_data_o, 32'd0);
    chk_eq("rst_sel",   {28'd0, wb_sel_o}, 32'd0);
    rst = 1'b1;

    // Basic two-word copy, zero stall.
    poke(1, 32'hA5A5_A5A5);
    poke(2, 32'h1234_5678);
    poke(257, 32'h0);
    poke(258, 32'h0);
    d0 = done_cnt;
    start_copy(11'h004, 11'h404, 10'd2);
    wait_done(200, lat, seen);
    chk_eq("t1_done_seen", {31'd0, seen}, 32'd1);
    chk_eq("t1_latency", lat, 32'd8);
    chk_eq("t1_err", {31'd0, err_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk_eq("t1_ram404", mem[257], 32'hA5A5_A5A5);
    chk_eq("t1_ram408", mem[258], 32'h1234_5678);
    chk_eq("t1_words", {22'd0, words_o}, 32'd2);
    chk_eq("t1_done_pulses", done_cnt - d0, 32'd1);
    chk_eq("t1_idle", {31'd0, busy_o}, 32'd0);

    // Zero-length copy.
    c0 = cyc_cnt;
    d0 = done_cnt;
    start_copy(11'h010, 11'h020, 10'd0);
    wait_done(20, lat, seen);
    chk_eq("t2_done_seen", {31'd0, seen}, 32'd1);
    chk_eq("t2_latency", lat, 32'd0);
    repeat (2) @(negedge clk);
    chk_eq("t2_no_cyc", cyc_cnt - c0, 32'd0);
    chk_eq("t2_done_pulses", done_cnt - d0, 32'd1);
    chk_eq("t2_words", {22'd0, words_o}, 32'd0);

    // Three stall cycles per request.
    stall_n = 3;
    poke(16, 32'hDEAD_BEEF);
    poke(17, 32'hCAFE_F00D);
    poke(64, 32'h0);
    poke(65, 32'h0);
    s0  = stab_err;
    sc0 = stall_cyc;
    start_copy(11'h040, 11'h100, 10'd2);
    wait_done(400, lat, seen);
    chk_eq("t3_done_seen", {31'd0, seen}, 32'd1);
    chk_eq("t3_latency", lat, 32'd20);
    repeat (2) @(negedge clk);
    chk_eq("t3_ram100", mem[64], 32'hDEAD_BEEF);
    chk_eq("t3_ram104", mem[65], 32'hCAFE_F00D);
    chk_eq("t3_stb_addr_stable", stab_err - s0, 32'd0);
    chk_eq("t3_stall_cycles", stall_cyc - sc0, 32'd12);
    stall_n = 0;

    // Address wrap from the top word to word 0.
    poke(511, 32'h1111_2222);
    poke(0,   32'h3333_4444);
    poke(128, 32'h0);
    poke(129, 32'h0);
    r0 = rd_n;
    start_copy(11'h7FC, 11'h200, 10'd2);
    wait_done(200, lat, seen);
    chk_eq("t4_done_seen", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    chk_eq("t4_rd0_addr", {21'd0, rd_log[r0[5:0]]}, 32'h7FC);
    r0 = r0 + 1;
    chk_eq("t4_rd1_addr", {21'd0, rd_log[r0[5:0]]}, 32'h000);
    chk_eq("t4_ram200", mem[128], 32'h1111_2222);
    chk_eq("t4_ram204", mem[129], 32'h3333_4444);

    // start_i while busy must be ignored.
    poke(32, 32'hAAAA_0001);
    poke(33, 32'hBBBB_0002);
    poke(34, 32'hCCCC_0003);
    poke(192, 32'h0);
    poke(193, 32'h0);
    poke(194, 32'h0);
    poke(320, 32'h0);
    d0 = done_cnt;
    start_copy(11'h080, 11'h300, 10'd3);
    repeat (3) @(posedge clk);
    #1;
    src_addr_i = 11'h004;
    dst_addr_i = 11'h500;
    len_i      = 10'd1;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
    wait_done(200, lat, seen);
    chk_eq("t5_done_seen", {31'd0, seen}, 32'd1);
    chk_eq("t5_latency", lat, 32'd8);
    repeat (2) @(negedge clk);
    chk_eq("t5_ram300", mem[192], 32'hAAAA_0001);
    chk_eq("t5_ram304", mem[193], 32'hBBBB_0002);
    chk_eq("t5_ram308", mem[194], 32'hCCCC_0003);
    chk_eq("t5_ram500_untouched", mem[320], 32'h0);
    chk_eq("t5_words", {22'd0, words_o}, 32'd3);
    chk_eq("t5_done_pulses", done_cnt - d0, 32'd1);
    chk_eq("t5_idle", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset in the middle of a copy.
    d0 = done_cnt;
    start_copy(11'h004, 11'h600, 10'd2);
    repeat (2) @(negedge clk);
    chk_eq("t6_active", {31'd0, wb_cyc_o}, 32'd1);
    rst = 1'b0;
    #1;
    chk_eq("t6_ctrl",  {26'd0, busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk_eq("t6_addr",  {21'd0, wb_addr_o}, 32'd0);
    chk_eq("t6_data",  wb_data_o, 32'd0);
    chk_eq("t6_sel",   {28'd0, wb_sel_o}, 32'd0);
    chk_eq("t6_words", {22'd0, words_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("t6_no_done", done_cnt - d0, 32'd0);
    chk_eq("t6_idle", {31'd0, busy_o}, 32'd0);

`ifdef WB_COPY_TIMEOUT_EN
    // Ack never returned: watchdog aborts after 16 cycles in RD_WAIT.
    no_ack = 1'b1;
    start_copy(11'h004, 11'h600, 10'd1);
    wait_done(100, lat, seen);
    chk_eq("t7_done_seen", {31'd0, seen}, 32'd1);
    chk_eq("t7_latency", lat, 32'd17);
    chk_eq("t7_err", {31'd0, err_o}, 32'd1);
    chk_eq("t7_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
    start_copy(11'h004, 11'h600, 10'd0);
    wait_done(20, lat, seen);
    chk_eq("t7_err_cleared", {31'd0, err_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_copy_engine.md
WB_COPY_ENGINE -- requirements
Module: wb_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 11, meaning the Wishbone byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the Wishbone data width.
REQ-003 The block SHALL have parameter SEL_WIDTH, default 4, meaning the byte-select width (DATA_WIDTH/8).
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the watchdog limit; it is used only with WB_COPY_TIMEOUT_EN.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset asserted).
REQ-007 The block SHALL have port start_i, input, 1 bit: a one-cycle copy request.
REQ-008 The block SHALL have port src_addr_i, input, ADDR_WIDTH bits: source byte address; bits [1:0] are ignored.
REQ-009 The block SHALL have port dst_addr_i, input, ADDR_WIDTH bits: destination byte address; bits [1:0] are ignored.
REQ-010 The block SHALL have port len_i, input, ADDR_WIDTH-1 bits: the copy length in words.
REQ-011 The block SHALL have status outputs busy_o (1 bit), done_o (1 bit, one-cycle pulse), err_o (1 bit) and words_o (ADDR_WIDTH-1 bits, count of words written).
REQ-012 The block SHALL have Wishbone master outputs wb_addr_o[ADDR_WIDTH], wb_data_o[DATA_WIDTH], wb_sel_o[SEL_WIDTH], wb_we_o, wb_cyc_o and wb_stb_o.
REQ-013 The block SHALL have Wishbone master inputs wb_data_i[DATA_WIDTH], wb_ack_i and wb_stall_i; this port connects directly to one port of the two-port Wishbone RAM.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and FIN.
REQ-015 In IDLE, start_i=1 SHALL latch src, dst and len, clear words_o and err_o, and move to RD_REQ, or to FIN if len=0.
REQ-016 start_i SHALL be ignored in every state other than IDLE.
REQ-017 In RD_REQ and WR_REQ, wb_stb_o=1 and wb_cyc_o=1; the request is accepted in a cycle with wb_stall_i=0, and on acceptance the FSM moves to the matching *_WAIT state with wb_stb_o=0 on the next cycle.
REQ-018 In the *_WAIT states, wb_cyc_o SHALL stay 1; on wb_ack_i=1, RD_WAIT captures wb_data_i into the data register and moves to WR_REQ.
REQ-019 On wb_ack_i=1, WR_WAIT SHALL increment words_o, advance src and dst by 4, and move to RD_REQ, or to FIN when words_o+1 equals len.
REQ-020 wb_cyc_o SHALL rise at the first RD_REQ and fall only when entering FIN, so it stays high across the whole copy.
REQ-021 wb_sel_o SHALL be all ones; wb_we_o SHALL be 1 only in WR_REQ/WR_WAIT; wb_data_o SHALL carry the captured word.
REQ-022 wb_addr_o SHALL be the current address with bits [1:0]=0, incremented modulo 2^ADDR_WIDTH, so 0x7FC+4 wraps to 0x000.
REQ-023 Exactly one transaction SHALL be outstanding at any time; a wb_ack_i seen outside a *_WAIT state is ignored.
REQ-024 FIN SHALL assert done_o for one cycle and return to IDLE; busy_o=1 in every state except IDLE.
REQ-025 Best-case throughput per word SHALL be 4 cycles with zero stall and single-cycle ack.

Reset
REQ-026 On rst=0, the block SHALL asynchronously enter IDLE and drive busy_o, done_o, err_o, wb_cyc_o, wb_stb_o and wb_we_o to 0, and words_o, wb_addr_o, wb_data_o and wb_sel_o to 0.
REQ-027 Reset asserted mid-copy SHALL drop cyc/stb immediately, without waiting for an outstanding ack, and SHALL not pulse done_o.

Configuration
REQ-028 With WB_COPY_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in any REQ or WAIT state and reset on every state change; reaching TIMEOUT_CYCLES goes to FIN with err_o=1, dropping cyc/stb.
REQ-029 Without WB_COPY_TIMEOUT_EN, err_o SHALL be tied 0 and the block SHALL wait indefinitely.

Structure
REQ-030 Package wb_copy_pkg SHALL hold the default widths, the state enum type and TIMEOUT_CYCLES_DEFAULT.
REQ-031 The watchdog SHALL be a sub-module, wb_copy_watchdog, instantiated only under WB_COPY_TIMEOUT_EN.

Verification
REQ-032 The bench SHALL cover: preload RAM 0x004=A5A5A5A5 and 0x008=12345678, copy src 0x004 to dst 0x404 with len=2 -> RAM 0x404=A5A5A5A5 and 0x408=12345678, words_o=2, one done_o pulse, err_o=0.
REQ-033 The bench SHALL cover: len=0 -> done_o one cycle after start, with no wb_cyc_o activity.
REQ-034 The bench SHALL cover: RAM port stalled 3 cycles per request -> wb_stb_o and wb_addr_o held stable until accepted, and the data copied correctly.
REQ-035 The bench SHALL cover: src 0x7FC with len=2 -> the second read is at 0x000 (wrap).
REQ-036 The bench SHALL cover: start_i pulsed while busy -> ignored, and the original copy completes unchanged.
REQ-037 The bench SHALL cover, with the macro defined: ack never returned -> err_o=1 and done_o pulse after 16 cycles in RD_WAIT, with cyc=0; and rst=0 mid-copy -> all outputs 0 at once.
